// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit
//  Description : HI/LO register unit with a multi-cycle restoring divider
//                (DIV/DIVU), single-cycle MTHI/MTLO moves and an optional
//                single-cycle multiplier (MULT/MULTU).
//                Optional feature macro: HILO_MULT_EN (enables MULT/MULTU).
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int         CW        = $clog2(W + 1);
    localparam logic [2:0] c_OP_DIV  = 3'b000;
    localparam logic [2:0] c_OP_DIVU = 3'b001;
    localparam logic [2:0] c_OP_MULT = 3'b010;
    localparam logic [2:0] c_OP_MULU = 3'b011;
    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   rem_q;       // partial remainder (always < divisor)
    logic [W-1:0]   quo_q;       // dividend bits shift out, quotient bits shift in
    logic [W-1:0]   dvs_q;       // divisor magnitude
    logic           qneg_q;      // quotient must be negated at the end
    logic           rneg_q;      // remainder must be negated at the end
    logic           dz_q;        // divide by zero: quotient forced to all ones
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           busy_q;
    logic           done_q;

    logic           is_signed;
    logic [W-1:0]   mag_a_d;
    logic [W-1:0]   mag_b_d;
    logic [W:0]     part_d;
    logic [W:0]     diff_d;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic [W-1:0]   hi_fix_d;
    logic [W-1:0]   lo_fix_d;

    // Operand magnitudes captured on the start edge (signed DIV only takes |x|)
    always_comb begin
        is_signed = (op == c_OP_DIV);
        mag_a_d   = (is_signed && a[W-1]) ? -a : a;
        mag_b_d   = (is_signed && b[W-1]) ? -b : b;
    end

    // One restoring shift-subtract step on the W+1-bit shifted remainder
    always_comb begin
        part_d = {rem_q, quo_q[W-1]};
        diff_d = part_d - {1'b0, dvs_q};
        if (!diff_d[W]) begin
            rem_d = diff_d[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_d = part_d[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
        end
    end

    // Sign correction applied when leaving FIX; remainder follows the dividend
    always_comb begin
        hi_fix_d = rneg_q ? -rem_q : rem_q;
        if (dz_q) begin
            lo_fix_d = '1;
        end else begin
            lo_fix_d = qneg_q ? -quo_q : quo_q;
        end
    end

`ifdef HILO_MULT_EN
    logic [2*W-1:0] prod_d;

    // Full-width product; op[0] selects unsigned
    always_comb begin
        if (op[0]) begin
            prod_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin
            prod_d = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        end
    end
`endif

    // Control FSM, divider datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_DIV, c_OP_DIVU: begin
                                state_q <= S_DIV;
                                cnt_q   <= CW'(W - 1);
                                rem_q   <= '0;
                                quo_q   <= mag_a_d;
                                dvs_q   <= mag_b_d;
                                qneg_q  <= is_signed && (a[W-1] ^ b[W-1]);
                                rneg_q  <= is_signed && a[W-1];
                                dz_q    <= (b == '0);
                                busy_q  <= 1'b1;
                            end
                            c_OP_MTHI: begin
                                hi_q   <= a;
                                done_q <= 1'b1;
                            end
                            c_OP_MTLO: begin
                                lo_q   <= a;
                                done_q <= 1'b1;
                            end
`ifdef HILO_MULT_EN
                            c_OP_MULT, c_OP_MULU: begin
                                hi_q   <= prod_d[2*W-1:W];
                                lo_q   <= prod_d[W-1:0];
                                done_q <= 1'b1;
                            end
`endif
                            default: ;  // reserved (and MULT when disabled)
                        endcase
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_fix_d;
                    lo_q    <= lo_fix_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/hilo_div_unit.md
HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL have parameter W, default 32, the operand width and the divide iteration count.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, an operation request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits, the operation code: 000 DIV, 001 DIVU, 010 MULT, 011 MULTU, 100 MTHI, 101 MTLO; 110 and 111 reserved.
REQ-006 The block SHALL have port a, input, W bits, the dividend, multiplicand or move source.
REQ-007 The block SHALL have port b, input, W bits, the divisor or multiplier.
REQ-008 The block SHALL have port hi, output, W bits, the HI register (remainder or upper product).
REQ-009 The block SHALL have port lo, output, W bits, the LO register (quotient or lower product).
REQ-010 The block SHALL have port busy, output, 1 bit, high while a divide is in progress; the pipeline stalls on it.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse that is high in the first cycle the new hi/lo values are visible.

Function
REQ-012 The FSM SHALL have three states: IDLE, DIV and FIX.
REQ-013 IDLE SHALL go to DIV on start with op 000 or 001; DIV SHALL go to FIX after exactly W cycles; FIX SHALL go to IDLE after 1 cycle.
REQ-014 The start edge SHALL latch the operand magnitudes (absolute values for DIV) and the result signs.
REQ-015 DIV SHALL perform one restoring shift-subtract iteration per cycle on a W+1-bit partial remainder.
REQ-016 On its exit edge, FIX SHALL apply the sign corrections and write lo and hi.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-017 Divide latency SHALL be exactly W+1 clock edges from the start edge to hi/lo update, with done=1 in the following cycle.
REQ-018 busy SHALL be 1 in DIV and FIX and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1; operands and op changes during a divide SHALL NOT affect the result.
REQ-020 A start in the same cycle as done=1 SHALL be accepted, allowing back-to-back divides.
REQ-021 Divide by zero SHALL take the full latency and yield lo = all ones and hi = a, for both signed and unsigned.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0.
REQ-023 MTHI and MTLO SHALL write hi or lo respectively from a on the start edge, with no busy and done=1 in the next cycle; the other register is unchanged.
REQ-024 Reserved op codes SHALL be no-ops: no state change and no done pulse.
REQ-025 hi and lo SHALL hold their values at all times except on an explicit write or reset.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL enter IDLE and set hi=0, lo=0, busy=0 and done=0.
REQ-027 Reset asserted mid-divide SHALL abort the divide at that edge: no hi/lo write, no done pulse.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro HILO_MULT_EN defined, MULT and MULTU SHALL write the full 2W-bit product (signed or unsigned) on the start edge, with hi = upper half, lo = lower half, no busy, and done=1 in the next cycle.
REQ-030 Without HILO_MULT_EN, op 010 and 011 SHALL be no-ops as in REQ-024, and no multiplier logic SHALL be synthesised.

Verification
REQ-031 The bench SHALL cover: DIV a=100, b=7 -> busy for 33 cycles, then done=1 with lo=14, hi=2.
REQ-032 The bench SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
REQ-033 The bench SHALL cover: DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 after 33 cycles; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 The bench SHALL cover: start pulsed on cycle 10 of a divide with different operands -> ignored, and the first result is unchanged; a second start in the done cycle -> accepted.
REQ-035 The bench SHALL cover: MTHI a=0xDEADBEEF, then reset asserted on divide cycle 15 -> hi=0, lo=0, busy=0, and no done pulse follows.
REQ-036 The bench SHALL cover: with HILO_MULT_EN, MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done next cycle; without HILO_MULT_EN -> hi/lo unchanged and no done.
